// File: rtl/nvdla_cdp_dp_lut_addr_pkg.sv
// -----------------------------------------------------------------------------
// nvdla_cdp_dp_lut_addr_pkg
// Shared definitions for the CDP LUT addressing stage: lane geometry, field
// offsets inside one 52-bit lane result word, table sizes, the stage-1
// intermediate record and two small helper functions.
// Lane result word, MSB to LSB:
//   {lo_oflow, lo_uflow, lo_frac[15:0], lo_idx[8:0],
//    le_oflow, le_uflow, le_frac[15:0], le_idx[6:0]}
// -----------------------------------------------------------------------------
package nvdla_cdp_dp_lut_addr_pkg;

    localparam int TP        = 1;              // lanes per beat
    localparam int ICVTO     = 9;              // input-convert bits per element
    localparam int SUM_W     = 2*ICVTO + 3;    // lane window-sum width (21)
    localparam int FRAC_W    = 16;
    localparam int LE_IDX_W  = 7;
    localparam int LO_IDX_W  = 9;
    localparam int LANE_PD_W = 52;
    localparam int LE_ENTRIES = 64;
    localparam int LO_ENTRIES = 256;

    // sum - start is evaluated as a 33-bit two's-complement value.
    localparam int DIFF_W = 33;
    // Leading-one position width and the signed exponent width
    // (position 0..20 minus an 8-bit signed offset spans -127..148).
    localparam int LOD_W  = $clog2(SUM_W);
    localparam int EXP_W  = 10;

    // Field offsets inside one lane result word.
    localparam int LE_IDX_LSB   = 0;
    localparam int LE_FRAC_LSB  = 7;
    localparam int LE_UFLOW_BIT = 23;
    localparam int LE_OFLOW_BIT = 24;
    localparam int LO_IDX_LSB   = 25;
    localparam int LO_FRAC_LSB  = 34;
    localparam int LO_UFLOW_BIT = 50;
    localparam int LO_OFLOW_BIT = 51;

    // Performance counter slots.
    typedef enum logic [1:0] {
        PERF_LE_UFLOW = 2'd0,
        PERF_LE_OFLOW = 2'd1,
        PERF_LO_UFLOW = 2'd2,
        PERF_LO_OFLOW = 2'd3
    } perf_sel_e;

    // Stage-1 result per lane: underflow already decided, index not yet clamped.
    typedef struct packed {
        logic              lo_neg;
        logic [SUM_W-1:0]  lo_q;
        logic [FRAC_W-1:0] lo_frac;
        logic              le_neg;
        logic [SUM_W-1:0]  le_q;
        logic [FRAC_W-1:0] le_frac;
    } s1_t;

    // Position of the most significant set bit; 0 for a zero input.
    function automatic logic [LOD_W-1:0] lead_one(input logic [SUM_W-1:0] v);
        logic [LOD_W-1:0] p;
        p = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (v[i]) p = LOD_W'(i);
        end
        return p;
    endfunction

    // a + b, pinned at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [32:0] b);
        logic [33:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s[33:32] != 2'b00) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/nvdla_cdp_lut_lane.sv
// -----------------------------------------------------------------------------
// nvdla_cdp_lut_lane
// One lane of LUT addressing. Stage 1 subtracts the table start, shifts
// (linear) or finds the leading one (exponential) and registers the raw
// index/fraction; stage 2 clamps against the table size and packs the
// 52-bit lane word. Load enables come from the handshake logic in the top.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn  clock, async active-low reset
//   s1_ld, s2_ld                      stage register load enables
//   sum                               unsigned lane window sum
//   le_* / lo_*                       static LUT configuration
//   pd                                registered lane result word
// -----------------------------------------------------------------------------
module nvdla_cdp_lut_lane
    import nvdla_cdp_dp_lut_addr_pkg::*;
(
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 s1_ld,
    input  logic                 s2_ld,
    input  logic [SUM_W-1:0]     sum,
    input  logic                 le_function,
    input  logic [31:0]          le_start,
    input  logic [7:0]           le_index_offset,
    input  logic [4:0]           le_index_select,
    input  logic [31:0]          lo_start,
    input  logic [4:0]           lo_index_select,
    output logic [LANE_PD_W-1:0] pd
);

    logic [DIFF_W-1:0]       lo_diff;
    logic [DIFF_W-1:0]       le_diff;
    logic [SUM_W+FRAC_W-1:0] lo_sh;
    logic [SUM_W+FRAC_W-1:0] le_sh;
    logic [LOD_W-1:0]        le_lead;
    logic [4:0]              le_amt;
    logic signed [EXP_W-1:0] le_exp;
    s1_t                     s1_new;
    s1_t                     s1_d;
    s1_t                     s1_q;
    logic [LANE_PD_W-1:0]    pd_new;
    logic [LANE_PD_W-1:0]    pd_d;
    logic [LANE_PD_W-1:0]    pd_q;

    // A non-negative difference never exceeds the sum, so its upper bits are
    // only needed as the sign.
    logic unused_lo_diff;
    assign unused_lo_diff = ^lo_diff[DIFF_W-2:SUM_W];

    // ---------------- stage 1: subtract, shift, leading-one ----------------
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        lo_diff = {{(DIFF_W-SUM_W){1'b0}}, sum} - {1'b0, lo_start};
        le_diff = {{(DIFF_W-SUM_W){1'b0}}, sum} - {1'b0, le_start};

        // {d,16'b0} >> n: upper SUM_W bits are d>>n, lower 16 the fraction.
        lo_sh   = {lo_diff[SUM_W-1:0], {FRAC_W{1'b0}}} >> lo_index_select;

        // One shifter serves both LE modes: shift by the select in linear
        // mode, by the leading-one position in exponential mode.
        le_lead = lead_one(le_diff[SUM_W-1:0]);
        le_amt  = le_function ? le_index_select : le_lead;
        le_sh   = {le_diff[SUM_W-1:0], {FRAC_W{1'b0}}} >> le_amt;
        le_exp  = $signed({{(EXP_W-LOD_W){1'b0}}, le_lead})
                - $signed({{(EXP_W-8){le_index_offset[7]}}, le_index_offset});

        s1_new.lo_neg  = lo_diff[DIFF_W-1];
        s1_new.lo_q    = lo_sh[SUM_W+FRAC_W-1:FRAC_W];
        s1_new.lo_frac = lo_sh[FRAC_W-1:0];

        if (le_function) begin
            s1_new.le_neg  = le_diff[DIFF_W-1];
            s1_new.le_q    = le_sh[SUM_W+FRAC_W-1:FRAC_W];
            s1_new.le_frac = le_sh[FRAC_W-1:0];
        end else begin
            // Zero has no leading one, and a negative exponent is below the table.
            s1_new.le_neg  = le_diff[DIFF_W-1] | (le_diff == '0) | le_exp[EXP_W-1];
            s1_new.le_q    = {{(SUM_W-(EXP_W-1)){1'b0}}, le_exp[EXP_W-2:0]};
            s1_new.le_frac = le_sh[FRAC_W-1:0];
        end

        s1_d = s1_ld ? s1_new : s1_q;
    end

    // ---------------- stage 2: clamp and pack ----------------
    always_comb begin
        pd_new = '0;

        if (s1_q.lo_neg) begin
            pd_new[LO_UFLOW_BIT] = 1'b1;
        end else if (s1_q.lo_q >= SUM_W'(LO_ENTRIES)) begin
            pd_new[LO_OFLOW_BIT]                = 1'b1;
            pd_new[LO_IDX_LSB +: LO_IDX_W]      = LO_IDX_W'(LO_ENTRIES);
        end else begin
            pd_new[LO_IDX_LSB +: LO_IDX_W]      = s1_q.lo_q[LO_IDX_W-1:0];
            pd_new[LO_FRAC_LSB +: FRAC_W]       = s1_q.lo_frac;
        end

        if (s1_q.le_neg) begin
            pd_new[LE_UFLOW_BIT] = 1'b1;
        end else if (s1_q.le_q >= SUM_W'(LE_ENTRIES)) begin
            pd_new[LE_OFLOW_BIT]                = 1'b1;
            pd_new[LE_IDX_LSB +: LE_IDX_W]      = LE_IDX_W'(LE_ENTRIES);
        end else begin
            pd_new[LE_IDX_LSB +: LE_IDX_W]      = s1_q.le_q[LE_IDX_W-1:0];
            pd_new[LE_FRAC_LSB +: FRAC_W]       = s1_q.le_frac;
        end

        pd_d = s2_ld ? pd_new : pd_q;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            // NOTE: data registers are reset too, so the output word reads zero out of reset.
            s1_q <= '0;
            pd_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            s1_q <= s1_d;
            pd_q <= pd_d;
        end
    end

    assign pd = pd_q;

endmodule

// File: rtl/nvdla_cdp_dp_lut_addr.sv
// -----------------------------------------------------------------------------
// nvdla_cdp_dp_lut_addr
// LUT address generation for CDP interpolation. Takes per-lane window sums
// and produces LE/LO table indices, 16-bit fractions and underflow/overflow
// flags through a two-stage valid/ready pipeline (one beat per cycle,
// two-cycle latency). Per-lane arithmetic lives in nvdla_cdp_lut_lane.
// Optional feature macro: NVDLA_CDP_LUT_PERF_EN
//   defined   - four saturating 32-bit flag counters, cleared by reg2dp_perf_clr
//   undefined - counter ports tied to zero, perf_clr ignored
// Ports:
//   nvdla_core_clk / nvdla_core_rstn   clock, async active-low reset
//   sum2itp_pvld/prdy/pd               input sum beats (TP lanes of SUM_W)
//   reg2dp_lut_*                       static LUT configuration
//   reg2dp_perf_clr                    counter clear pulse
//   lut2intp_pvld/prdy/pd              result beats (TP lanes of 52 bits)
//   dp2reg_*_cnt                       flag counters
// -----------------------------------------------------------------------------
module nvdla_cdp_dp_lut_addr
    import nvdla_cdp_dp_lut_addr_pkg::*;
(
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic                    sum2itp_pvld,
    output logic                    sum2itp_prdy,
    input  logic [TP*SUM_W-1:0]     sum2itp_pd,
    input  logic                    reg2dp_lut_le_function,
    input  logic [31:0]             reg2dp_lut_le_start,
    input  logic [7:0]              reg2dp_lut_le_index_offset,
    input  logic [4:0]              reg2dp_lut_le_index_select,
    input  logic [31:0]             reg2dp_lut_lo_start,
    input  logic [4:0]              reg2dp_lut_lo_index_select,
    input  logic                    reg2dp_perf_clr,
    output logic                    lut2intp_pvld,
    input  logic                    lut2intp_prdy,
    output logic [TP*LANE_PD_W-1:0] lut2intp_pd,
    output logic [31:0]             dp2reg_le_uflow_cnt,
    output logic [31:0]             dp2reg_le_oflow_cnt,
    output logic [31:0]             dp2reg_lo_uflow_cnt,
    output logic [31:0]             dp2reg_lo_oflow_cnt
);

    logic s1_vld_d, s1_vld_q;
    logic s2_vld_d, s2_vld_q;
    logic s1_rdy, s2_rdy;
    logic s1_ld, s2_ld;

    // A stage can take a new beat when it is empty or its beat is leaving.
    always_comb begin
        s2_rdy   = ~s2_vld_q | lut2intp_prdy;
        s1_rdy   = ~s1_vld_q | s2_rdy;
        s1_ld    = sum2itp_pvld & s1_rdy;
        s2_ld    = s1_vld_q & s2_rdy;
        s1_vld_d = s1_rdy ? sum2itp_pvld : s1_vld_q;
        s2_vld_d = s2_rdy ? s1_vld_q : s2_vld_q;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    assign sum2itp_prdy  = s1_rdy;
    assign lut2intp_pvld = s2_vld_q;

    for (genvar i = 0; i < TP; i++) begin : g_lane
        nvdla_cdp_lut_lane u_lane (
            .nvdla_core_clk  (nvdla_core_clk),
            .nvdla_core_rstn (nvdla_core_rstn),
            .s1_ld           (s1_ld),
            .s2_ld           (s2_ld),
            .sum             (sum2itp_pd[i*SUM_W +: SUM_W]),
            .le_function     (reg2dp_lut_le_function),
            .le_start        (reg2dp_lut_le_start),
            .le_index_offset (reg2dp_lut_le_index_offset),
            .le_index_select (reg2dp_lut_le_index_select),
            .lo_start        (reg2dp_lut_lo_start),
            .lo_index_select (reg2dp_lut_lo_index_select),
            .pd              (lut2intp_pd[i*LANE_PD_W +: LANE_PD_W])
        );
    end

`ifdef NVDLA_CDP_LUT_PERF_EN
    logic [31:0] perf_cnt_d [4];
    logic [31:0] perf_cnt_q [4];
    logic [32:0] perf_inc   [4];
    logic        out_fire;

    // Counters advance on the output handshake, one count per flagged lane.
    // A clear in the same cycle wins over the increment.
    always_comb begin
        out_fire = s2_vld_q & lut2intp_prdy;
        for (int c = 0; c < 4; c++) perf_inc[c] = '0;
        for (int i = 0; i < TP; i++) begin
            perf_inc[PERF_LE_UFLOW] += 33'(lut2intp_pd[i*LANE_PD_W + LE_UFLOW_BIT]);
            perf_inc[PERF_LE_OFLOW] += 33'(lut2intp_pd[i*LANE_PD_W + LE_OFLOW_BIT]);
            perf_inc[PERF_LO_UFLOW] += 33'(lut2intp_pd[i*LANE_PD_W + LO_UFLOW_BIT]);
            perf_inc[PERF_LO_OFLOW] += 33'(lut2intp_pd[i*LANE_PD_W + LO_OFLOW_BIT]);
        end
        for (int c = 0; c < 4; c++) begin
            if (reg2dp_perf_clr)  perf_cnt_d[c] = '0;
            else if (out_fire)    perf_cnt_d[c] = sat_add(perf_cnt_q[c], perf_inc[c]);
            else                  perf_cnt_d[c] = perf_cnt_q[c];
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int c = 0; c < 4; c++) perf_cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < 4; c++) perf_cnt_q[c] <= perf_cnt_d[c];
        end
    end

    assign dp2reg_le_uflow_cnt = perf_cnt_q[PERF_LE_UFLOW];
    assign dp2reg_le_oflow_cnt = perf_cnt_q[PERF_LE_OFLOW];
    assign dp2reg_lo_uflow_cnt = perf_cnt_q[PERF_LO_UFLOW];
    assign dp2reg_lo_oflow_cnt = perf_cnt_q[PERF_LO_OFLOW];
`else
    logic unused_perf_clr;
    assign unused_perf_clr     = reg2dp_perf_clr;
    assign dp2reg_le_uflow_cnt = '0;
    assign dp2reg_le_oflow_cnt = '0;
    assign dp2reg_lo_uflow_cnt = '0;
    assign dp2reg_lo_oflow_cnt = '0;
`endif

endmodule

// File: tb/tb_nvdla_cdp_dp_lut_addr.sv
// -----------------------------------------------------------------------------
// tb_nvdla_cdp_dp_lut_addr
// Directed and randomized stimulus for nvdla_cdp_dp_lut_addr with a
// behavioural LUT-addressing model and an in-order scoreboard.
// -----------------------------------------------------------------------------
module tb_nvdla_cdp_dp_lut_addr;
    import nvdla_cdp_dp_lut_addr_pkg::*;

`ifdef NVDLA_CDP_LUT_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                    clk;
    logic                    rstn;
    logic                    in_vld;
    logic                    in_rdy;
    logic [TP*SUM_W-1:0]     in_pd;
    logic                    le_function;
    logic [31:0]             le_start;
    logic [7:0]              le_offset;
    logic [4:0]              le_sel;
    logic [31:0]             lo_start;
    logic [4:0]              lo_sel;
    logic                    perf_clr;
    logic                    out_vld;
    logic                    out_rdy;
    logic [TP*LANE_PD_W-1:0] out_pd;
    logic [31:0]             cnt_le_uf, cnt_le_of, cnt_lo_uf, cnt_lo_of;

    nvdla_cdp_dp_lut_addr dut (
        .nvdla_core_clk             (clk),
        .nvdla_core_rstn            (rstn),
        .sum2itp_pvld               (in_vld),
        .sum2itp_prdy               (in_rdy),
        .sum2itp_pd                 (in_pd),
        .reg2dp_lut_le_function     (le_function),
        .reg2dp_lut_le_start        (le_start),
        .reg2dp_lut_le_index_offset (le_offset),
        .reg2dp_lut_le_index_select (le_sel),
        .reg2dp_lut_lo_start        (lo_start),
        .reg2dp_lut_lo_index_select (lo_sel),
        .reg2dp_perf_clr            (perf_clr),
        .lut2intp_pvld              (out_vld),
        .lut2intp_prdy              (out_rdy),
        .lut2intp_pd                (out_pd),
        .dp2reg_le_uflow_cnt        (cnt_le_uf),
        .dp2reg_le_oflow_cnt        (cnt_le_of),
        .dp2reg_lo_uflow_cnt        (cnt_lo_uf),
        .dp2reg_lo_oflow_cnt        (cnt_lo_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_in     = 0;
    int n_out    = 0;
    logic [TP*LANE_PD_W-1:0] exp_q[$];
    longint exp_cnt [4];   // le_uflow, le_oflow, lo_uflow, lo_oflow

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Lane result from the addressing rules, in plain integer arithmetic.
    function automatic logic [LANE_PD_W-1:0] lane_model(input longint s);
        longint d, q, f;
        longint lo_idx, lo_frac, le_idx, le_frac;
        logic   lo_of, lo_uf, le_of, le_uf;
        int     p, e;
        lo_of = 0; lo_uf = 0; le_of = 0; le_uf = 0;
        lo_idx = 0; lo_frac = 0; le_idx = 0; le_frac = 0;

        d = s - longint'(lo_start);
        if (d < 0) begin
            lo_uf = 1;
        end else begin
            q = d >> lo_sel;
            f = ((d << 16) >> lo_sel) & 64'hFFFF;
            if (q >= 256) begin lo_of = 1; lo_idx = 256; end
            else begin lo_idx = q; lo_frac = f; end
        end

        d = s - longint'(le_start);
        if (le_function) begin
            if (d < 0) begin
                le_uf = 1;
            end else begin
                q = d >> le_sel;
                f = ((d << 16) >> le_sel) & 64'hFFFF;
                if (q >= 64) begin le_of = 1; le_idx = 64; end
                else begin le_idx = q; le_frac = f; end
            end
        end else if (d <= 0) begin
            le_uf = 1;
        end else begin
            p = 0;
            while ((d >> (p + 1)) != 0) p++;
            e = p - int'($signed(le_offset));
            if (e < 0) le_uf = 1;
            else if (e >= 64) begin le_of = 1; le_idx = 64; end
            else begin le_idx = e; le_frac = ((d << 16) >> p) & 64'hFFFF; end
        end
        return {lo_of, lo_uf, lo_frac[15:0], lo_idx[8:0],
                le_of, le_uf, le_frac[15:0], le_idx[6:0]};
    endfunction

    // One clock: account handshakes just before the rising edge, then return
    // shortly after the falling edge where the caller may drive and inspect.
    task automatic tick();
        logic [TP*LANE_PD_W-1:0] e;
        longint flag;
        #2;
        if (in_vld && in_rdy) begin
            for (int i = 0; i < TP; i++)
                e[i*LANE_PD_W +: LANE_PD_W] = lane_model(longint'(in_pd[i*SUM_W +: SUM_W]));
            exp_q.push_back(e);
            n_in++;
        end
        e = '0;
        if (out_vld && out_rdy) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL out_unexpected observed=beat expected=none");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("out_pd[%0d]", n_out), 64'(out_pd), 64'(e));
            end
            n_out++;
        end
        for (int c = 0; c < 4; c++) begin
            flag = 0;
            if (out_vld && out_rdy) begin
                for (int i = 0; i < TP; i++) begin
                    case (c)
                        0: flag += longint'(e[i*LANE_PD_W + 23]);
                        1: flag += longint'(e[i*LANE_PD_W + 24]);
                        2: flag += longint'(e[i*LANE_PD_W + 50]);
                        default: flag += longint'(e[i*LANE_PD_W + 51]);
                    endcase
                end
            end
            if (perf_clr) exp_cnt[c] = 0;
            else if (exp_cnt[c] + flag > 64'hFFFF_FFFF) exp_cnt[c] = 64'hFFFF_FFFF;
            else exp_cnt[c] = exp_cnt[c] + flag;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_perf(input string tag);
        check({tag, "_le_uf"}, 64'(cnt_le_uf), PERF ? exp_cnt[0] : 0);
        check({tag, "_le_of"}, 64'(cnt_le_of), PERF ? exp_cnt[1] : 0);
        check({tag, "_lo_uf"}, 64'(cnt_lo_uf), PERF ? exp_cnt[2] : 0);
        check({tag, "_lo_of"}, 64'(cnt_lo_of), PERF ? exp_cnt[3] : 0);
    endtask

    // Present one beat, then wait until its result sits on the output.
    task automatic send(input int s);
        in_pd  = SUM_W'(s);
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check(tag, 64'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_in0, n_out0, s, base;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        rstn = 1'b0; in_vld = 1'b0; in_pd = '0; out_rdy = 1'b1; perf_clr = 1'b0;
        le_function = 1'b1; le_start = '0; le_offset = '0; le_sel = '0;
        lo_start = '0; lo_sel = '0;
        repeat (2) @(negedge clk);
        #1;

        // Reset state
        check("rst_out_vld", 64'(out_vld), 0);
        check("rst_out_pd", 64'(out_pd), 0);
        check("rst_in_rdy", 64'(in_rdy), 1);
        check_perf("rst_cnt");
        rstn = 1'b1;
        tick();

        // LO linear: 111-100=11, >>2 -> idx 2, frac 0xC000; two-cycle latency
        lo_start = 100; lo_sel = 2;
        in_pd = SUM_W'(111); in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check("lat_not_yet", 64'(out_vld), 0);
        tick();
        check("lat_out_vld", 64'(out_vld), 1);
        check("lo111_idx", 64'(out_pd[33:25]), 2);
        check("lo111_frac", 64'(out_pd[49:34]), 64'hC000);
        check("lo111_flags", 64'(out_pd[51:50]), 0);
        tick();

        send(50);
        check("lo50_uflow", 64'(out_pd[51:50]), 2'b01);
        check("lo50_idx_frac", 64'(out_pd[49:25]), 0);
        tick();

        send(1124);
        check("lo1124_oflow", 64'(out_pd[51:50]), 2'b10);
        check("lo1124_idx", 64'(out_pd[33:25]), 256);
        check("lo1124_frac", 64'(out_pd[49:34]), 0);
        tick();

        // LE exponential
        le_function = 1'b0; le_start = 0; le_offset = 0;
        send(40);
        check("le40_idx", 64'(out_pd[6:0]), 5);
        check("le40_frac", 64'(out_pd[22:7]), 64'h4000);
        check("le40_flags", 64'(out_pd[24:23]), 0);
        tick();

        send(0);
        check("le0_uflow", 64'(out_pd[24:23]), 2'b01);
        check("le0_idx", 64'(out_pd[6:0]), 0);
        tick();

        le_offset = 8'hC4;   // -60
        send(1024);
        check("le1024_oflow", 64'(out_pd[24:23]), 2'b10);
        check("le1024_idx", 64'(out_pd[6:0]), 64);
        tick();

        // Backpressure: three beats offered while the output is stalled
        n_in0 = n_in; n_out0 = n_out;
        out_rdy = 1'b0; in_vld = 1'b1;
        in_pd = SUM_W'(7);    tick();
        in_pd = SUM_W'(500);  tick();
        in_pd = SUM_W'(3000);
        check("bp_in_rdy_low", 64'(in_rdy), 0);
        repeat (3) tick();
        check("bp_accepted_two", 64'(n_in - n_in0), 2);
        check("bp_out_vld", 64'(out_vld), 1);
        out_rdy = 1'b1;
        for (int k = 0; k < 10 && (n_in - n_in0) < 3; k++) tick();
        in_vld = 1'b0;
        check("bp_accepted_three", 64'(n_in - n_in0), 3);
        drain("bp_queue_empty");
        check("bp_delivered", 64'(n_out - n_out0), 3);

        // Randomized traffic, configuration changed only while idle
        for (int ep = 0; ep < 4; ep++) begin
            le_function = 1'($urandom_range(0, 1));
            le_start    = $urandom_range(0, 1 << 20);
            lo_start    = $urandom_range(0, 1 << 20);
            le_sel      = 5'($urandom_range(0, 12));
            lo_sel      = 5'($urandom_range(0, 12));
            le_offset   = 8'($urandom_range(0, 30) - 10);
            for (int cyc = 0; cyc < 200; cyc++) begin
                in_vld = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 2))
                    0: s = int'($urandom_range(0, (1 << SUM_W) - 1));
                    default: begin
                        base = ($urandom_range(0, 1) != 0) ? int'(lo_start) : int'(le_start);
                        s = base + int'($urandom_range(0, 4096)) - 2048;
                    end
                endcase
                if (s < 0) s = 0;
                if (s > (1 << SUM_W) - 1) s = (1 << SUM_W) - 1;
                in_pd   = SUM_W'(s);
                out_rdy = ($urandom_range(0, 2) != 0);
                tick();
            end
            in_vld = 1'b0; out_rdy = 1'b1;
            drain($sformatf("rand%0d_queue_empty", ep));
            check_perf($sformatf("rand%0d_cnt", ep));
        end
        check("rand_in_out_equal", 64'(n_out), 64'(n_in));

        // Reset with both stages full
        out_rdy = 1'b0; in_vld = 1'b1;
        in_pd = SUM_W'(123); tick();
        in_pd = SUM_W'(456); tick();
        in_vld = 1'b0;
        check("rst_full_out_vld", 64'(out_vld), 1);
        check("rst_full_in_rdy", 64'(in_rdy), 0);
        rstn = 1'b0;
        #1;
        check("rst_async_vld", 64'(out_vld), 0);
        check("rst_async_pd", 64'(out_pd), 0);
        exp_q.delete();
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        tick();
        rstn = 1'b1; out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rst_no_stale%0d", k), 64'(out_vld), 0);
        end
        check_perf("rst_mid_cnt");

        // Flag counters: four overflow beats, then a clear racing an overflow
        le_function = 1'b1; le_start = 0; le_sel = 0; lo_start = 0; lo_sel = 0;
        for (int k = 0; k < 4; k++) begin
            send(300);
            tick();
        end
        check("perf_lo_oflow_4", 64'(cnt_lo_of), PERF ? 4 : 0);
        check("perf_le_oflow_4", 64'(cnt_le_of), PERF ? 4 : 0);
        check_perf("perf_after4");
        send(300);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        check("perf_clr_wins", 64'(cnt_lo_of), 0);
        check_perf("perf_after_clr");
        drain("final_queue_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
